// File: rtl/mem_stage.sv
// mem_stage - memory-access stage of the five-stage RISC-V pipeline.
//
// Takes the EX/MEM register contents, drives a word-addressed data-cache
// port, freezes the upstream pipeline while the cache stalls, and registers
// the MEM/WB outputs used by write-back and forwarding.
//
// State table:
//   state | meaning
//   IDLE  | no access outstanding, or the current access completes this cycle
//   BUSY  | cache stalling an outstanding load/store; upstream frozen
//
// Ports:
//   clk, rst         pipeline clock, synchronous active-high reset
//   alu_result       EX/MEM address or ALU result
//   second_opr       EX/MEM store data (rs2)
//   rd_in            destination register
//   memrd_in/memwr_in/mem2reg_in/regwr_in  EX/MEM control bits
//   dcache_ren/wen   cache read/write request (write wins when both set)
//   dcache_addr      word address, alu_result[BIT_W-1:2]
//   dcache_wdata     store data, byte-swapped when SWAP_ENDIAN
//   dcache_rdata     load data from cache
//   dcache_stall     cache busy
//   stall_out        freeze PC, IF/ID, ID/EX, EX/MEM
//   wb_data, rd_out, regwr_out, mem2reg_out  MEM/WB register
//   stall_cnt        saturating count of stall cycles since reset
module mem_stage #(
  parameter int BIT_W       = 32,
  parameter bit SWAP_ENDIAN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIT_W-1:0] alu_result,
  input  logic [BIT_W-1:0] second_opr,
  input  logic [4:0]       rd_in,
  input  logic             memrd_in,
  input  logic             memwr_in,
  input  logic             mem2reg_in,
  input  logic             regwr_in,
  output logic             dcache_ren,
  output logic             dcache_wen,
  output logic [BIT_W-3:0] dcache_addr,
  output logic [BIT_W-1:0] dcache_wdata,
  input  logic [BIT_W-1:0] dcache_rdata,
  input  logic             dcache_stall,
  output logic             stall_out,
  output logic [BIT_W-1:0] wb_data,
  output logic [4:0]       rd_out,
  output logic             regwr_out,
  output logic             mem2reg_out,
  output logic [15:0]      stall_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic             mem_op;
  logic [BIT_W-1:0] load_data;

  // Little-endian core vs big-endian cache: reverse byte order.
  function automatic logic [BIT_W-1:0] byte_rev(input logic [BIT_W-1:0] d);
    logic [BIT_W-1:0] r;
    r = '0;
    for (int i = 0; i < BIT_W / 8; i++) begin
      r[8*i +: 8] = d[BIT_W-8-8*i +: 8];
    end
    return r;
  endfunction

  assign mem_op       = memrd_in | memwr_in;
  assign dcache_wen   = memwr_in;
  assign dcache_ren   = memrd_in & ~memwr_in;
  assign dcache_addr  = alu_result[BIT_W-1:2];
  assign dcache_wdata = SWAP_ENDIAN ? byte_rev(second_opr) : second_opr;
  assign load_data    = SWAP_ENDIAN ? byte_rev(dcache_rdata) : dcache_rdata;

  // Combinational so the freeze lands in the same cycle the cache stalls;
  // a non-memory instruction never stalls regardless of dcache_stall.
  assign stall_out = mem_op & dcache_stall;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_op && dcache_stall) state_nxt = BUSY;
      BUSY:    if (!dcache_stall)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // MEM/WB register. A stall cycle inserts a bubble: controls drop, while
  // rd_out/wb_data keep their last values so forwarding sees nothing new.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data     <= '0;
      rd_out      <= '0;
      regwr_out   <= 1'b0;
      mem2reg_out <= 1'b0;
    end else if (stall_out) begin
      regwr_out   <= 1'b0;
      mem2reg_out <= 1'b0;
    end else begin
      rd_out      <= rd_in;
      regwr_out   <= regwr_in;
      mem2reg_out <= mem2reg_in;
      wb_data     <= mem2reg_in ? load_data : alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_out && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result, second_opr, dcache_rdata;
  logic [4:0]  rd_in;
  logic        memrd_in, memwr_in, mem2reg_in, regwr_in, dcache_stall;
  logic        dcache_ren, dcache_wen, stall_out;
  logic [29:0] dcache_addr;
  logic [31:0] dcache_wdata, wb_data;
  logic [4:0]  rd_out;
  logic        regwr_out, mem2reg_out;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  mem_stage #(.BIT_W(32), .SWAP_ENDIAN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .alu_result(alu_result), .second_opr(second_opr), .rd_in(rd_in),
    .memrd_in(memrd_in), .memwr_in(memwr_in), .mem2reg_in(mem2reg_in),
    .regwr_in(regwr_in),
    .dcache_ren(dcache_ren), .dcache_wen(dcache_wen),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_stall(dcache_stall),
    .stall_out(stall_out), .wb_data(wb_data), .rd_out(rd_out),
    .regwr_out(regwr_out), .mem2reg_out(mem2reg_out), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sop;
    logic [4:0]  rd;
    logic        rd_en;
    logic        wr_en;
    logic        m2r;
    logic        rw;
    logic [31:0] rdata;
    logic        stall;
    logic        e_ren;
    logic        e_wen;
    logic [29:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic [31:0] e_wb;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic        e_m2r;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] sop, input logic [4:0] rd,
                       input logic rde, input logic wre, input logic m2r, input logic rw,
                       input logic [31:0] rdata, input logic stall);
    alu_result = alu; second_opr = sop; rd_in = rd;
    memrd_in = rde; memwr_in = wre; mem2reg_in = m2r; regwr_in = rw;
    dcache_rdata = rdata; dcache_stall = stall;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          alu           sop           rd   rd wr m2r rw rdata         st  ren wen addr           wdata         so  wb            rd   rw m2r
    vecs[0] = '{32'h0000_1234, 32'h0,        5'd5,  0, 0, 0, 1, 32'h0,        1, 0, 0, 30'h48D,      32'h0,        0, 32'h0000_1234, 5'd5,  1, 0};
    vecs[1] = '{32'h0000_0040, 32'h0,        5'd7,  1, 0, 1, 1, 32'h1122_3344, 0, 1, 0, 30'h10,       32'h0,        0, 32'h4433_2211, 5'd7,  1, 1};
    vecs[2] = '{32'h0000_0100, 32'hAABB_CCDD, 5'd0, 1, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 30'h40,       32'hDDCC_BBAA, 0, 32'h0000_0100, 5'd0,  0, 0};
    vecs[3] = '{32'h0000_0008, 32'h0102_0304, 5'd3, 0, 1, 0, 1, 32'h0,        0, 0, 1, 30'h2,        32'h0403_0201, 0, 32'h0000_0008, 5'd3,  1, 0};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0,        5'd31, 1, 0, 1, 1, 32'hDEAD_BEEF, 0, 1, 0, 30'h3FFF_FFFF, 32'h0,        0, 32'hEFBE_ADDE, 5'd31, 1, 1};
    vecs[5] = '{32'hCAFE_F00D, 32'h0,        5'd1,  0, 0, 0, 0, 32'h1234_5678, 1, 0, 0, 30'h32BF_BC03, 32'h0,        0, 32'hCAFE_F00D, 5'd1,  0, 0};

    // Reset held two cycles with random inputs.
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom, 1'($urandom));
      #1;
      chk("rst_ren", {31'b0, dcache_ren}, {31'b0, memrd_in & ~memwr_in});
      chk("rst_wen", {31'b0, dcache_wen}, {31'b0, memwr_in});
      tick();
    end
    chk("rst_wb", wb_data, 32'h0);
    chk("rst_rd", {27'b0, rd_out}, 32'h0);
    chk("rst_regwr", {31'b0, regwr_out}, 32'h0);
    chk("rst_m2r", {31'b0, mem2reg_out}, 32'h0);
    chk("rst_cnt", {16'b0, stall_cnt}, 32'h0);
    chk("rst_fsm", {31'b0, dut.state}, 32'h0);
    rst = 1'b0;

    // Single-cycle vectors: ALU pass-through, hits, stores, non-mem under stall.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].alu, vecs[i].sop, vecs[i].rd, vecs[i].rd_en, vecs[i].wr_en,
            vecs[i].m2r, vecs[i].rw, vecs[i].rdata, vecs[i].stall);
      #1;
      chk($sformatf("v%0d_ren", i), {31'b0, dcache_ren}, {31'b0, vecs[i].e_ren});
      chk($sformatf("v%0d_wen", i), {31'b0, dcache_wen}, {31'b0, vecs[i].e_wen});
      chk($sformatf("v%0d_addr", i), {2'b0, dcache_addr}, {2'b0, vecs[i].e_addr});
      chk($sformatf("v%0d_wdata", i), dcache_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_stall", i), {31'b0, stall_out}, {31'b0, vecs[i].e_stall});
      tick();
      chk($sformatf("v%0d_wb", i), wb_data, vecs[i].e_wb);
      chk($sformatf("v%0d_rd", i), {27'b0, rd_out}, {27'b0, vecs[i].e_rd});
      chk($sformatf("v%0d_regwr", i), {31'b0, regwr_out}, {31'b0, vecs[i].e_rw});
      chk($sformatf("v%0d_m2r", i), {31'b0, mem2reg_out}, {31'b0, vecs[i].e_m2r});
    end
    chk("tbl_cnt", {16'b0, stall_cnt}, 32'h0);

    // Load miss with 3 stall cycles: 3 bubbles, then the swapped load data.
    drive(32'h0000_0200, 32'h0, 5'd9, 1, 0, 1, 1, 32'h5566_7788, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("miss%0d_stall", c), {31'b0, stall_out}, 32'h1);
      chk($sformatf("miss%0d_ren", c), {31'b0, dcache_ren}, 32'h1);
      tick();
      chk($sformatf("miss%0d_regwr", c), {31'b0, regwr_out}, 32'h0);
      chk($sformatf("miss%0d_m2r", c), {31'b0, mem2reg_out}, 32'h0);
      chk($sformatf("miss%0d_rd_hold", c), {27'b0, rd_out}, 32'd1);
      chk($sformatf("miss%0d_wb_hold", c), wb_data, 32'hCAFE_F00D);
      chk($sformatf("miss%0d_fsm", c), {31'b0, dut.state}, 32'h1);
    end
    dcache_stall = 1'b0;
    #1;
    chk("miss_done_stall", {31'b0, stall_out}, 32'h0);
    tick();
    chk("miss_wb", wb_data, 32'h8877_6655);
    chk("miss_rd", {27'b0, rd_out}, 32'd9);
    chk("miss_regwr", {31'b0, regwr_out}, 32'h1);
    chk("miss_m2r", {31'b0, mem2reg_out}, 32'h1);
    chk("miss_cnt", {16'b0, stall_cnt}, 32'd3);
    chk("miss_fsm", {31'b0, dut.state}, 32'h0);

    // Back-to-back hit store directly after the miss.
    drive(32'h0000_0020, 32'h1122_3344, 5'd4, 0, 1, 0, 0, 32'h0, 0);
    #1;
    chk("b2b_wdata", dcache_wdata, 32'h4433_2211);
    tick();
    chk("b2b_wb", wb_data, 32'h0000_0020);
    chk("b2b_rd", {27'b0, rd_out}, 32'd4);

    // Reset during the second stall cycle of a miss.
    drive(32'h0000_0300, 32'h0, 5'd12, 1, 0, 1, 1, 32'hA5A5_A5A5, 1);
    tick();
    chk("rm_cnt1", {16'b0, stall_cnt}, 32'd4);
    rst = 1'b1;
    tick();
    chk("rm_fsm", {31'b0, dut.state}, 32'h0);
    chk("rm_wb", wb_data, 32'h0);
    chk("rm_rd", {27'b0, rd_out}, 32'h0);
    chk("rm_regwr", {31'b0, regwr_out}, 32'h0);
    chk("rm_cnt", {16'b0, stall_cnt}, 32'h0);
    rst = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 32'h0, 1);
    #1;
    chk("rm_stall_clr", {31'b0, stall_out}, 32'h0);
    tick();
    chk("rm_cnt_idle", {16'b0, stall_cnt}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline. It consumes the EX/MEM pipeline register contents produced by the execute stage (ALU result, store data, destination register, memory and write-back controls). It drives a word-addressed data-cache port and freezes the upstream pipeline while the cache stalls. It registers the MEM/WB pipeline outputs consumed by write-back and forwarding.

## Interface
- BIT_W, 32, datapath width
- SWAP_ENDIAN, 1, 1 = byte-swap store data and load data between the little-endian core and the big-endian cache
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- alu_result  input  BIT_W  EX/MEM address or ALU result
- second_opr  input  BIT_W  EX/MEM store data (rs2)
- rd_in  input  5  destination register
- memrd_in, memwr_in, mem2reg_in, regwr_in  input  1 each  control bits from EX/MEM
- dcache_ren  output  1  read request
- dcache_wen  output  1  write request
- dcache_addr  output  BIT_W-2  word address = alu_result[BIT_W-1:2]
- dcache_wdata  output  BIT_W  store data (swapped if SWAP_ENDIAN)
- dcache_rdata  input  BIT_W  load data
- dcache_stall  input  1  cache busy; access completes in the first cycle the request is high and dcache_stall is low
- stall_out  output  1  freeze PC, IF/ID, ID/EX and EX/MEM registers
- wb_data  output  BIT_W  MEM/WB result: load data if mem2reg, else alu_result
- rd_out  output  5  MEM/WB destination register
- regwr_out, mem2reg_out  output  1  MEM/WB controls
- stall_cnt  output  16  saturating count of stall cycles since reset

## Operation
- Clock is clk. Reset rst is synchronous and active-high.
- mem_op = memrd_in | memwr_in. If memrd_in and memwr_in are both high, the write takes priority: dcache_ren is forced to 0.
- FSM states:
  - IDLE
    - If mem_op and dcache_stall: go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY
    - While dcache_stall is high: stay in BUSY.
    - When dcache_stall is low: the access completes and the FSM returns to IDLE.
- Requests:
  - dcache_ren = memrd_in & ~memwr_in and dcache_wen = memwr_in, in both states.
  - Upstream is frozen by stall_out, so the inputs stay stable for the whole access.
- stall_out = mem_op & dcache_stall. This is combinational, so the freeze applies in the same cycle as the stall.
- Load data:
  - load_data = SWAP_ENDIAN ? byte-reverse(dcache_rdata) : dcache_rdata.
  - Byte-reverse maps bits [7:0]↔[31:24] and [15:8]↔[23:16].
  - The same mapping is applied to second_opr to form dcache_wdata.
- MEM/WB register, on each rising edge:
  - If stall_out: load a bubble. regwr_out=0 and mem2reg_out=0; rd_out and wb_data hold their previous values.
  - Else: rd_out<=rd_in, regwr_out<=regwr_in, mem2reg_out<=mem2reg_in, wb_data<= mem2reg_in ? load_data : alu_result.
- stall_cnt increments on every cycle with stall_out=1 and saturates at 16'hFFFF.
- On reset mid-access: FSM goes to IDLE, all MEM/WB outputs clear, and stall_cnt clears. Outstanding cache requests are abandoned; the cache is reset by the same rst.

## Timing
- Reset values: wb_data=0, rd_out=0, regwr_out=0, mem2reg_out=0, stall_cnt=0, FSM=IDLE.
- dcache_ren, dcache_wen, dcache_addr, dcache_wdata and stall_out are combinational from the inputs.
- Latency:
  - Non-memory instruction or cache hit (dcache_stall=0): 1 cycle. The result appears on the MEM/WB outputs at the next edge.
  - Miss with N stall cycles: N+1 cycles; N bubbles are inserted, then the result.
- A non-memory instruction never asserts stall_out, even if dcache_stall is high.
- Back-to-back memory operations need no idle cycle between them.

## Test plan
- Reset: hold rst=1 for 2 cycles with random inputs -> all registered outputs 0 and stall_cnt=0; dcache_ren/wen follow the inputs.
- ALU pass-through: alu_result=32'h0000_1234, regwr_in=1, rd_in=5, mem2reg_in=0, dcache_stall=1 -> stall_out=0; next edge wb_data=32'h0000_1234, rd_out=5, regwr_out=1.
- Load hit with swap: memrd_in=1, mem2reg_in=1, alu_result=32'h0000_0040, dcache_rdata=32'h1122_3344, dcache_stall=0 -> dcache_addr=30'h10; next edge wb_data=32'h4433_2211.
- Load miss, 3 stall cycles: dcache_stall high for 3 cycles then low -> stall_out high for exactly 3 cycles, 3 bubbles (regwr_out=0), then the correct wb_data; stall_cnt=3.
- Store: memwr_in=1, memrd_in=1, second_opr=32'hAABB_CCDD -> dcache_wen=1, dcache_ren=0, dcache_wdata=32'hDDCC_BBAA; regwr_out follows regwr_in.
- Reset mid-miss: assert rst during the 2nd stall cycle -> next edge FSM=IDLE, outputs 0, stall_cnt=0; with inputs cleared, stall_out=0.
